// File: rtl/mmcm_ps_servo_ctrl.sv
// mmcm_ps_servo_ctrl
// Closed-loop sequencer for the MMCM dynamic phase-shift port. Each measurement
// round flushes the moving-average error filter, waits for it to settle, then
// compares the filtered error against a deadband. An out-of-band error produces
// one psen step in the correcting direction. The block also tracks the phase
// position, lock status and psdone timeouts.
//
// Optional feature: define SERVO_STEP_CNT_EN to build the completed-step
// counter. Without it, step_count is tied to 0.
//
// Ports:
//   clk          system clock
//   reset_in_n   asynchronous active-low reset
//   enable       servo run request (level)
//   mmcm_locked  MMCM LOCKED status
//   err_filt     signed filtered phase error (WIDTH bits)
//   filt_reset   synchronous active-high reset to the filter (FLUSH cycle)
//   psen         phase-shift enable, 1-cycle pulse
//   psincdec     step direction, 1 = increment, valid with psen
//   psdone       phase-shift done pulse from the MMCM
//   ps_pos       signed accumulated step position (16 bits)
//   in_lock      error in band for LOCK_COUNT consecutive evaluations
//   at_limit     last requested step was suppressed by POS_LIMIT
//   busy         sequencer not idle
//   timeout_err  sticky psdone timeout flag
//   step_count   completed steps (0 unless SERVO_STEP_CNT_EN)
module mmcm_ps_servo_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEADBAND      = 16,
    parameter int unsigned SETTLE_CYCLES = 34,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned POS_LIMIT     = 1023,
    parameter int unsigned PS_TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset_in_n,
    input  logic             enable,
    input  logic             mmcm_locked,
    input  logic [WIDTH-1:0] err_filt,
    output logic             filt_reset,
    output logic             psen,
    output logic             psincdec,
    input  logic             psdone,
    output logic [15:0]      ps_pos,
    output logic             in_lock,
    output logic             at_limit,
    output logic             busy,
    output logic             timeout_err,
    output logic [31:0]      step_count
);

    localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(PS_TIMEOUT + 1);
    localparam int unsigned MagW = WIDTH + 1;

    localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYCLES);
    localparam logic [ToW-1:0]  ToLoad     = ToW'(PS_TIMEOUT);
    localparam logic [7:0]      LockMax    = 8'(LOCK_COUNT);
    localparam logic [15:0]     PosMax     = 16'(POS_LIMIT);
    localparam logic [15:0]     PosMin     = -PosMax;
    localparam logic [MagW-1:0] Deadband   = MagW'(DEADBAND);

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StSettle,
        StEval,
        StStep,
        StWaitDone,
        StFault
    } state_e;

    state_e          state_q, state_d;
    logic [SetW-1:0] settle_q, settle_d;
    logic [ToW-1:0]  to_q, to_d;
    logic [7:0]      lock_cnt_q, lock_cnt_d;
    logic [15:0]     ps_pos_q, ps_pos_d;
    logic            in_lock_q, in_lock_d;
    logic            at_limit_q, at_limit_d;
    logic            psincdec_q, psincdec_d;
    logic            timeout_err_q, timeout_err_d;
    logic            filt_reset_q, psen_q, busy_q;
    logic            locked_q;

    logic            abort;
    logic            dir_now;
    logic [MagW-1:0] err_ext, err_mag;

    // Magnitude is taken one bit wider so the most negative input cannot wrap
    // back into the deadband.
    assign err_ext = {err_filt[WIDTH-1], err_filt};
    assign err_mag = err_filt[WIDTH-1] ? -err_ext : err_ext;
    assign dir_now = !err_filt[WIDTH-1] && (err_filt != '0);
    assign abort   = !enable || !mmcm_locked;

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        to_d          = to_q;
        lock_cnt_d    = lock_cnt_q;
        in_lock_d     = in_lock_q;
        at_limit_d    = at_limit_q;
        psincdec_d    = psincdec_q;
        timeout_err_d = timeout_err_q;
        ps_pos_d      = ps_pos_q;

        unique case (state_q)
            StIdle: begin
                if (enable && mmcm_locked) begin
                    state_d       = StFlush;
                    timeout_err_d = 1'b0;
                end
            end
            StFlush, StSettle, StEval, StStep: begin
                if (abort) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                    in_lock_d  = 1'b0;
                end else if (state_q == StFlush) begin
                    settle_d = SettleLoad;
                    state_d  = StSettle;
                end else if (state_q == StSettle) begin
                    settle_d = settle_q - SetW'(1);
                    if (settle_q <= SetW'(1)) begin
                        state_d = StEval;
                    end
                end else if (state_q == StEval) begin
                    settle_d = SettleLoad;
                    if (err_mag <= Deadband) begin
                        if (lock_cnt_q < LockMax) begin
                            lock_cnt_d = lock_cnt_q + 8'd1;
                        end
                        in_lock_d  = (lock_cnt_d == LockMax);
                        at_limit_d = 1'b0;
                        state_d    = StSettle;
                    end else begin
                        lock_cnt_d = '0;
                        in_lock_d  = 1'b0;
                        if ((dir_now && ps_pos_q == PosMax) ||
                            (!dir_now && ps_pos_q == PosMin)) begin
                            at_limit_d = 1'b1;
                            state_d    = StSettle;
                        end else begin
                            at_limit_d = 1'b0;
                            psincdec_d = dir_now;
                            state_d    = StStep;
                        end
                    end
                end else begin
                    to_d    = ToLoad;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                // Abort requests wait here until the outstanding step resolves.
                if (psdone) begin
                    ps_pos_d = psincdec_q ? ps_pos_q + 16'd1 : ps_pos_q - 16'd1;
                    if (abort) begin
                        state_d    = StIdle;
                        lock_cnt_d = '0;
                        in_lock_d  = 1'b0;
                    end else begin
                        state_d = StFlush;
                    end
                end else if (to_q <= ToW'(1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = StFault;
                end else begin
                    to_d = to_q - ToW'(1);
                end
            end
            StFault: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An MMCM relock zeroes its phase, so our position follows.
        if (locked_q && !mmcm_locked) begin
            ps_pos_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state_q       <= StIdle;
            settle_q      <= '0;
            to_q          <= '0;
            lock_cnt_q    <= '0;
            ps_pos_q      <= '0;
            in_lock_q     <= 1'b0;
            at_limit_q    <= 1'b0;
            psincdec_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            filt_reset_q  <= 1'b0;
            psen_q        <= 1'b0;
            busy_q        <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            to_q          <= to_d;
            lock_cnt_q    <= lock_cnt_d;
            ps_pos_q      <= ps_pos_d;
            in_lock_q     <= in_lock_d;
            at_limit_q    <= at_limit_d;
            psincdec_q    <= psincdec_d;
            timeout_err_q <= timeout_err_d;
            filt_reset_q  <= (state_d == StFlush);
            psen_q        <= (state_d == StStep);
            busy_q        <= (state_d != StIdle);
            locked_q      <= mmcm_locked;
        end
    end

`ifdef SERVO_STEP_CNT_EN
    logic        step_done;
    logic [31:0] step_count_q;

    assign step_done = (state_q == StWaitDone) && psdone;

    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            step_count_q <= '0;
        end else if (step_done) begin
            step_count_q <= step_count_q + 32'd1;
        end
    end

    assign step_count = step_count_q;
`else
    assign step_count = '0;
`endif

    assign filt_reset  = filt_reset_q;
    assign psen        = psen_q;
    assign psincdec    = psincdec_q;
    assign ps_pos      = ps_pos_q;
    assign in_lock     = in_lock_q;
    assign at_limit    = at_limit_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/mmcm_ps_servo_ctrl.md
Name: mmcm_ps_servo_ctrl

Overview:
- Closed-loop sequencer for the MMCM dynamic phase-shift port.
- Consumes the moving-average-filtered phase error and flushes the filter before each measurement.
- Waits for the filter to settle, then evaluates the error against a deadband and issues one psen step in the correcting direction.
- Tracks accumulated phase position, lock status and protocol faults.

Parameters:
- WIDTH, 32, width of signed filtered error input.
- DEADBAND, 16, |err| <= DEADBAND counts as in-band (unsigned, < 2**(WIDTH-1)).
- SETTLE_CYCLES, 34, wait cycles after filter flush; must be >= 2**SIZE+2 of the filter (default SIZE=5).
- LOCK_COUNT, 4, consecutive in-band evaluations required to assert in_lock (1..255).
- POS_LIMIT, 1023, max |ps_pos|; steps beyond are suppressed.
- PS_TIMEOUT, 255, max cycles to wait for psdone after psen.

Ports:
- clk  in  1  system clock
- reset_in_n  in  1  asynchronous, active-low reset
- enable  in  1  servo run request (level)
- mmcm_locked  in  1  MMCM LOCKED status
- err_filt  in  WIDTH  signed filtered phase error
- filt_reset  out  1  synchronous active-high reset to filter
- psen  out  1  MMCM phase-shift enable, 1-cycle pulse
- psincdec  out  1  1=increment, 0=decrement; valid with psen
- psdone  in  1  MMCM phase-shift done pulse
- ps_pos  out  16  signed accumulated step position
- in_lock  out  1  error in band for LOCK_COUNT evaluations
- at_limit  out  1  last requested step suppressed by POS_LIMIT
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky psdone timeout flag
- step_count  out  32  completed steps (see Optional Feature)

Behaviour:
- All outputs registered.
- Reset (async assert, sync deassert by upstream): state=IDLE; all outputs 0; counters 0.
- State transitions:
  - IDLE: enable=1 and mmcm_locked=1 -> FLUSH.
  - FLUSH (1 cycle): filt_reset=1; load settle counter=SETTLE_CYCLES -> SETTLE.
  - SETTLE: decrement each cycle; counter reaches 0 -> EVAL (exactly SETTLE_CYCLES cycles spent).
  - EVAL (1 cycle): mag = |err_filt| computed in WIDTH+1 bits, so -2**(WIDTH-1) is out-of-band, no overflow.
    - mag <= DEADBAND: lock_cnt++ saturating at LOCK_COUNT; in_lock=1 when lock_cnt==LOCK_COUNT; at_limit=0 -> SETTLE (reload, no flush).
    - Out of band: lock_cnt=0, in_lock=0; dir = (err_filt > 0).
    - If dir=1 and ps_pos==+POS_LIMIT, or dir=0 and ps_pos==-POS_LIMIT: at_limit=1 -> SETTLE.
    - Otherwise at_limit=0 -> STEP.
  - STEP (1 cycle): psen=1, psincdec=dir; load timeout counter=PS_TIMEOUT -> WAIT_DONE.
  - WAIT_DONE: psen=0, psincdec held.
    - psdone=1: ps_pos += dir?+1:-1; step_count++ -> FLUSH.
    - Timeout reaches 0 without psdone: timeout_err=1 -> FAULT.
  - FAULT: no psen; stays until enable=0 -> IDLE. timeout_err is cleared on the IDLE->FLUSH transition.
- Abort: enable=0 or mmcm_locked=0 in FLUSH/SETTLE/EVAL/STEP -> IDLE next cycle; in_lock=0, lock_cnt=0. A psen already issued in STEP still completes. In WAIT_DONE, abort is deferred until psdone (pos updated) or timeout.
- mmcm_locked falling edge, any state: ps_pos cleared to 0 on the next cycle (MMCM relock zeroes phase); overrides psdone update that cycle.
- psdone outside WAIT_DONE, including the STEP cycle: ignored.
- Only one psen is outstanding at any time. psen never asserted in consecutive cycles.
- First psen after enable: FLUSH at cycle 0, SETTLE cycles 1..SETTLE_CYCLES, EVAL at SETTLE_CYCLES+1, psen at SETTLE_CYCLES+2.

Optional Feature:
- Macro SERVO_STEP_CNT_EN.
- Defined: step_count is a 32-bit wrapping counter of completed steps, cleared only by reset.
- Undefined: counter logic absent; step_count tied to 0.

Test Plan:
- Reset then enable=1, locked=1, err_filt=+100 -> filt_reset pulse at cycle 0, psen=1 with psincdec=1 at cycle 36; psdone 5 cycles later -> ps_pos=1, next filt_reset the following cycle.
- err_filt=-17 -> psincdec=0 steps; err_filt=-16 and +16 -> no psen. After 4 in-band evaluations in_lock=1; err_filt=+17 on the next evaluation -> in_lock=0.
- err_filt=0x80000000 (most negative) -> treated out-of-band, decrement step, no wrap to in-band.
- POS_LIMIT=3, err_filt=+100 -> ps_pos reaches 3, then at_limit=1 and no further psen; err_filt=-100 -> step, at_limit=0, ps_pos=2.
- psdone withheld -> timeout_err=1 after 255 cycles in WAIT_DONE; stays in FAULT with enable=1; enable=0 -> IDLE; enable=1 -> timeout_err=0.
- enable=0 during WAIT_DONE -> stays until psdone, ps_pos updated, then IDLE. mmcm_locked=0 -> ps_pos=0 next cycle. reset_in_n low mid-SETTLE -> all outputs 0 immediately.
